// File: rtl/spi_master_ctrl.sv
//==============================================================================
// Module      : spi_master_ctrl
// Description : SPI master for the SPI-slave/RAM wrapper. Frames one
//               {op,payload} command per handshake on SS_n/MOSI and captures
//               the returned byte on MISO for read-data commands.
//               Optional build macro: SPI_MASTER_SEQ_CHK_EN (rd_data ordering
//               check with seq_err pulse).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_master_ctrl #(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_LATENCY = 2,
    parameter int SS_GAP     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_SIZE-1:0] cmd_data,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_data,
    output logic                 busy,
    output logic                 MOSI,
    output logic                 SS_n,
`ifdef SPI_MASTER_SEQ_CHK_EN
    output logic                 seq_err,
`endif
    input  logic                 MISO
);

    localparam int FRAME_W = ADDR_SIZE + 2;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int DLY_W   = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_RECV  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t                r_state, w_state_nx;
    logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt_nx, w_bit_dec;
    logic [DLY_W-1:0]      r_dly_cnt, w_dly_cnt_nx;
    logic [FRAME_W-1:0]    r_frame, w_frame_nx, w_frame_in;
    logic [ADDR_SIZE-1:0]  r_rx_sh, w_rx_sh_nx;
    logic [ADDR_SIZE-1:0]  r_rsp_data, w_rsp_data_nx;
    logic                  r_cmd_ready, w_cmd_ready_nx;
    logic                  r_rsp_valid, w_rsp_valid_nx;
    logic                  r_busy, w_busy_nx;
    logic                  r_mosi, w_mosi_nx;
    logic                  r_ss_n, w_ss_n_nx;
    logic                  w_accept;
    logic                  w_reject;
`ifdef SPI_MASTER_SEQ_CHK_EN
    logic                  r_rd_addr_done, w_rd_addr_done_nx;
    logic                  r_seq_err, w_seq_err_nx;
`endif

    assign w_accept   = cmd_valid && r_cmd_ready;
    assign w_bit_dec  = r_bit_cnt - BIT_W'(1);
    // rd_data carries no payload; its data bits go out as zero
    assign w_frame_in = (cmd_op == 2'b11) ? {cmd_op, {ADDR_SIZE{1'b0}}} : {cmd_op, cmd_data};

`ifdef SPI_MASTER_SEQ_CHK_EN
    assign w_reject = (cmd_op == 2'b11) && !r_rd_addr_done;
`else
    assign w_reject = 1'b0;
`endif

    // Outputs are computed from the next state so every output is a flop
    always_comb begin
        w_state_nx     = r_state;
        w_bit_cnt_nx   = r_bit_cnt;
        w_dly_cnt_nx   = r_dly_cnt;
        w_frame_nx     = r_frame;
        w_rx_sh_nx     = r_rx_sh;
        w_rsp_data_nx  = r_rsp_data;
        w_cmd_ready_nx = 1'b0;
        w_rsp_valid_nx = 1'b0;
        w_busy_nx      = 1'b1;
        w_mosi_nx      = 1'b0;
        w_ss_n_nx      = 1'b1;
`ifdef SPI_MASTER_SEQ_CHK_EN
        w_rd_addr_done_nx = r_rd_addr_done;
        w_seq_err_nx      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cmd_ready_nx = 1'b1;
                w_busy_nx      = 1'b0;
                if (w_accept) begin
                    w_cmd_ready_nx = 1'b0;
                    if (w_reject) begin
`ifdef SPI_MASTER_SEQ_CHK_EN
                        w_seq_err_nx = 1'b1;
`endif
                    end else begin
                        w_frame_nx = w_frame_in;
                        w_state_nx = S_SEL;
                        w_ss_n_nx  = 1'b0;
                        w_mosi_nx  = w_frame_in[FRAME_W-1];
                        w_busy_nx  = 1'b1;
                    end
                end
            end
            S_SEL: begin
                w_state_nx   = S_SHIFT;
                w_bit_cnt_nx = BIT_W'(FRAME_W - 1);
                w_ss_n_nx    = 1'b0;
                w_mosi_nx    = r_frame[FRAME_W-1];
            end
            S_SHIFT: begin
                if (r_bit_cnt != '0) begin
                    w_bit_cnt_nx = w_bit_dec;
                    w_ss_n_nx    = 1'b0;
                    w_mosi_nx    = r_frame[w_bit_dec];
                end else if (r_frame[FRAME_W-1 -: 2] == 2'b11) begin
                    w_ss_n_nx = 1'b0;
                    if (RD_LATENCY > 0) begin
                        w_state_nx   = S_WAIT;
                        w_dly_cnt_nx = DLY_W'(RD_LATENCY - 1);
                    end else begin
                        w_state_nx   = S_RECV;
                        w_bit_cnt_nx = BIT_W'(ADDR_SIZE - 1);
                    end
                end else begin
                    w_state_nx   = S_GAP;
                    w_dly_cnt_nx = DLY_W'(SS_GAP - 1);
`ifdef SPI_MASTER_SEQ_CHK_EN
                    if (r_frame[FRAME_W-1 -: 2] == 2'b10)
                        w_rd_addr_done_nx = 1'b1;
`endif
                end
            end
            S_WAIT: begin
                w_ss_n_nx = 1'b0;
                if (r_dly_cnt != '0) begin
                    w_dly_cnt_nx = r_dly_cnt - DLY_W'(1);
                end else begin
                    w_state_nx   = S_RECV;
                    w_bit_cnt_nx = BIT_W'(ADDR_SIZE - 1);
                end
            end
            S_RECV: begin
                w_rx_sh_nx = {r_rx_sh[ADDR_SIZE-2:0], MISO};
                if (r_bit_cnt != '0) begin
                    w_bit_cnt_nx = w_bit_dec;
                    w_ss_n_nx    = 1'b0;
                end else begin
                    w_state_nx     = S_GAP;
                    w_dly_cnt_nx   = DLY_W'(SS_GAP - 1);
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_data_nx  = w_rx_sh_nx;
`ifdef SPI_MASTER_SEQ_CHK_EN
                    w_rd_addr_done_nx = 1'b0;
`endif
                end
            end
            S_GAP: begin
                if (r_dly_cnt != '0) begin
                    w_dly_cnt_nx = r_dly_cnt - DLY_W'(1);
                end else begin
                    w_state_nx     = S_IDLE;
                    w_cmd_ready_nx = 1'b1;
                    w_busy_nx      = 1'b0;
                end
            end
            default: begin
                w_state_nx     = S_IDLE;
                w_cmd_ready_nx = 1'b1;
                w_busy_nx      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_dly_cnt   <= '0;
            r_frame     <= '0;
            r_rx_sh     <= '0;
            r_rsp_data  <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_mosi      <= 1'b0;
            r_ss_n      <= 1'b1;
`ifdef SPI_MASTER_SEQ_CHK_EN
            r_rd_addr_done <= 1'b0;
            r_seq_err      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_bit_cnt   <= w_bit_cnt_nx;
            r_dly_cnt   <= w_dly_cnt_nx;
            r_frame     <= w_frame_nx;
            r_rx_sh     <= w_rx_sh_nx;
            r_rsp_data  <= w_rsp_data_nx;
            r_cmd_ready <= w_cmd_ready_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_busy      <= w_busy_nx;
            r_mosi      <= w_mosi_nx;
            r_ss_n      <= w_ss_n_nx;
`ifdef SPI_MASTER_SEQ_CHK_EN
            r_rd_addr_done <= w_rd_addr_done_nx;
            r_seq_err      <= w_seq_err_nx;
`endif
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;
    assign MOSI      = r_mosi;
    assign SS_n      = r_ss_n;
`ifdef SPI_MASTER_SEQ_CHK_EN
    assign seq_err   = r_seq_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
//==============================================================================
// Module      : tb_spi_master_ctrl
// Description : Self-checking bench for spi_master_ctrl with a behavioural
//               SPI-slave/RAM model on the serial pins.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_spi_master_ctrl;

    localparam int ADDR_SIZE  = 8;
    localparam int RD_LATENCY = 2;
    localparam int SS_GAP     = 1;
    localparam int LIM        = 300;
    localparam int RECV_FIRST = 11 + RD_LATENCY;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       MOSI;
    logic       SS_n;
    logic       MISO = 1'b0;
`ifdef SPI_MASTER_SEQ_CHK_EN
    logic       seq_err;
`endif

    spi_master_ctrl #(
        .ADDR_SIZE (ADDR_SIZE),
        .RD_LATENCY(RD_LATENCY),
        .SS_GAP    (SS_GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .MOSI     (MOSI),
        .SS_n     (SS_n),
`ifdef SPI_MASTER_SEQ_CHK_EN
        .seq_err  (seq_err),
`endif
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    // Slave/RAM model: samples the master's pins on the falling edge
    int         lowcnt = 0, highcnt = 100, last_len = 0, last_gap = 0, prev_gap = 0;
    int         frames = 0, mosi_nz = 0, rsp_cnt = 0;
    logic [9:0] rx = '0, last_frame = '0;
    logic       sel_bit = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] wr_addr = '0, rd_addr = '0, tx = '0, rsp_seen = '0;

    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_seen = rsp_data;
        end
        if (!SS_n) begin
            if (lowcnt == 0) begin
                prev_gap = last_gap;
                last_gap = highcnt;
                frames++;
                sel_bit = MOSI;
            end else if (lowcnt <= 10) begin
                rx = {rx[8:0], MOSI};
            end else if (MOSI) begin
                mosi_nz++;
            end
            if (lowcnt == 10) begin
                last_frame = rx;
                case (rx[9:8])
                    2'b00: wr_addr = rx[7:0];
                    2'b01: mem[wr_addr] = rx[7:0];
                    2'b10: rd_addr = rx[7:0];
                    default: tx = mem[rd_addr];
                endcase
            end
            if (lowcnt >= RECV_FIRST && lowcnt < RECV_FIRST + 8)
                MISO = tx[RECV_FIRST + 7 - lowcnt];
            else
                MISO = 1'b0;
            lowcnt++;
            last_len = lowcnt;
            highcnt  = 0;
        end else begin
            highcnt++;
            lowcnt = 0;
            MISO   = 1'b0;
        end
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_accept(input logic [1:0] op, input logic [7:0] data);
        int t = 0;
        while (!cmd_ready && t < LIM) begin
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", int'(t < LIM), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < LIM) begin
            @(negedge clk);
            t++;
        end
        chk("busy_timeout", int'(t < LIM), 1);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [9:0] frame;
        int         len;
        int         nrsp;
        logic [7:0] rsp;
    } vec_t;

    vec_t       v [10];
    logic [7:0] hold = 8'h00;

    task automatic run_vec(input vec_t vv);
        int         r0;
        logic [9:0] f;
        f  = vv.frame;
        r0 = rsp_cnt;
        do_accept(vv.op, vv.data);
        wait_idle();
        @(negedge clk);
        chk("frame_bits", int'(last_frame), int'(vv.frame));
        chk("sel_bit", int'(sel_bit), int'(f[9]));
        chk("ss_low_len", last_len, vv.len);
        chk("rsp_pulses", rsp_cnt - r0, vv.nrsp);
        if (vv.nrsp != 0) begin
            chk("rsp_byte", int'(rsp_seen), int'(vv.rsp));
            hold = vv.rsp;
        end
        chk("rsp_data_hold", int'(rsp_data), int'(hold));
        chk("ready_after", int'(cmd_ready), 1);
    endtask

    initial begin
        int          r0, f0, t;
        logic [7:0]  b2b_data [3];
        logic [1:0]  b2b_op [3];

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        v[0] = '{2'd0, 8'h3A, 10'h03A, 11, 0, 8'h00};
        v[1] = '{2'd1, 8'h5C, 10'h15C, 11, 0, 8'h00};
        v[2] = '{2'd2, 8'h3A, 10'h23A, 11, 0, 8'h00};
        v[3] = '{2'd3, 8'hFF, 10'h300, 21, 1, 8'h5C};
        v[4] = '{2'd0, 8'h81, 10'h081, 11, 0, 8'h00};
        v[5] = '{2'd1, 8'hA5, 10'h1A5, 11, 0, 8'h00};
        v[6] = '{2'd2, 8'h81, 10'h281, 11, 0, 8'h00};
        v[7] = '{2'd3, 8'h00, 10'h300, 21, 1, 8'hA5};
        v[8] = '{2'd2, 8'h3A, 10'h23A, 11, 0, 8'h00};
        v[9] = '{2'd3, 8'h12, 10'h300, 21, 1, 8'h5C};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_ss_n", int'(SS_n), 1);
        chk("rst_mosi", int'(MOSI), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_busy", int'(busy), 0);

`ifdef SPI_MASTER_SEQ_CHK_EN
        // rd_data with no prior rd_addr is refused
        do_accept(2'd3, 8'h00);
        chk("seq_err_pulse", int'(seq_err), 1);
        chk("seq_ss_n", int'(SS_n), 1);
        chk("seq_ready_low", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        chk("seq_err_clear", int'(seq_err), 0);
        chk("seq_ready_back", int'(cmd_ready), 1);
        repeat (3) @(negedge clk);
        chk("seq_no_frame", frames, 0);
        chk("seq_no_rsp", rsp_cnt, 0);
`endif

        for (int i = 0; i < 10; i++) run_vec(v[i]);
        chk("ram_3a", int'(mem[8'h3A]), 8'h5C);
        chk("mosi_idle_in_read", mosi_nz, 0);

        // Back-to-back writes with cmd_valid held high
        b2b_op   = '{2'd0, 2'd1, 2'd0};
        b2b_data = '{8'h10, 8'h77, 8'h20};
        f0 = frames;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!cmd_ready && t < LIM) begin
                @(negedge clk);
                t++;
            end
            chk("b2b_ready_timeout", int'(t < LIM), 1);
            cmd_op   = b2b_op[k];
            cmd_data = b2b_data[k];
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        chk("b2b_frames", frames - f0, 3);
        chk("b2b_gap_1", prev_gap, SS_GAP + 1);
        chk("b2b_gap_2", last_gap, SS_GAP + 1);
        chk("b2b_ram_10", int'(mem[8'h10]), 8'h77);
        chk("b2b_wr_addr", int'(wr_addr), 8'h20);

        // Reset during SHIFT bit 4 (frame 0x0D3: bit 4 is 1)
        r0 = rsp_cnt;
        do_accept(2'd0, 8'hD3);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_pre_ss_n", int'(SS_n), 0);
        chk("abort_pre_mosi", int'(MOSI), 1);
        chk("abort_pre_busy", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ss_n", int'(SS_n), 1);
        chk("abort_mosi", int'(MOSI), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_rsp", rsp_cnt - r0, 0);
        chk("abort_rsp_data", int'(rsp_data), 0);
        hold = 8'h00;
        run_vec(v[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
